lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit directly upstream of the 8-word data cache.
- Accepts one load/store request per cycle from EX and drives the cache port (address, write data, read/write strobes).
- Performs byte/halfword extraction with sign or zero extension for loads, and two-cycle read-modify-write for sub-word stores.
- Registers load results toward writeback; stalls upstream during RMW.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu_mem_stage.sv | 118 +++++++++++
 tb/tb_lsu_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package lsu_pkg;

  // Access size encodings; 3 decodes as a word access
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Lane widths inside a 32-bit word
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic {IDLE, RMW} state_t;

  // Size 2 and 3 both mean a full word, so bit 1 alone decides it
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: load extract/extend and sub-word store merge.
// Purely combinational; lane logic assumes a 32-bit word, little-endian.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  ld_word,
  input  logic [1:0]        ld_lane,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic [WIDTH-1:0]  ld_data,
  input  logic [WIDTH-1:0]  st_old,
  input  logic [HALF_W-1:0] st_new,
  input  logic [1:0]        st_lane,
  input  logic              st_half,
  output logic [WIDTH-1:0]  st_merged
);

  logic [BYTE_W-1:0] ld_b;
  logic [HALF_W-1:0] ld_h;

  // Load: pick the addressed lane, then sign- or zero-extend it
  always_comb begin
    ld_b = ld_word[7:0];
    case (ld_lane)
      2'd0: ld_b = ld_word[7:0];
      2'd1: ld_b = ld_word[15:8];
      2'd2: ld_b = ld_word[23:16];
      default: ld_b = ld_word[31:24];
    endcase
    ld_h = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    if (is_word(ld_size))
      ld_data = ld_word;
    else if (ld_size == SZ_HALF)
      ld_data = {{(WIDTH-HALF_W){ld_h[HALF_W-1] & ld_signed}}, ld_h};
    else
      ld_data = {{(WIDTH-BYTE_W){ld_b[BYTE_W-1] & ld_signed}}, ld_b};
  end

  // Store: overwrite only the addressed lane of the old word
  always_comb begin
    st_merged = st_old;
    if (st_half) begin
      if (st_lane[1]) st_merged[31:16] = st_new;
      else            st_merged[15:0]  = st_new;
    end else begin
      case (st_lane)
        2'd0: st_merged[7:0]   = st_new[7:0];
        2'd1: st_merged[15:8]  = st_new[7:0];
        2'd2: st_merged[23:16] = st_new[7:0];
        default: st_merged[31:24] = st_new[7:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit in front of the 8-word data cache.
// Loads: one-cycle registered result. Word stores: single cycle.
// Sub-word stores: read in IDLE (stalling EX), merged write in RMW.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// suppressed and flagged on misalign instead of being silently aligned.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] dc_address,
  output logic [WIDTH-1:0] dc_data_in,
  output logic             dc_read,
  output logic             dc_write,
  input  logic [WIDTH-1:0] dc_data_out,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign
);

  state_t             state;
  logic [WIDTH-1:0]   rmw_addr;
  logic [WIDTH-1:0]   rmw_word;
  logic [HALF_W-1:0]  rmw_wdata;
  logic               rmw_half;
  logic [WIDTH-1:0]   ld_data;
  logic [WIDTH-1:0]   merged;
  logic               is_idle;
  logic               req_word;
  logic               mis;
  logic               do_load;
  logic               do_wstore;
  logic               do_rmw;

  assign is_idle  = (state == IDLE);
  assign req_word = is_word(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = req_valid &
               (((req_size == SZ_HALF) & req_addr[0]) | (req_word & (|req_addr[1:0])));
`else
  assign mis = 1'b0;
`endif

  assign do_load   = is_idle & req_valid & ~req_write & ~mis;
  assign do_wstore = is_idle & req_valid &  req_write &  req_word & ~mis;
  assign do_rmw    = is_idle & req_valid &  req_write & ~req_word & ~mis;

  // Strobes are forced low while reset is held so an aborted RMW never writes
  assign dc_read    = ~RST & (do_load | do_rmw);
  assign dc_write   = ~RST & (do_wstore | (state == RMW));
  assign stall      = ~RST & do_rmw;
  assign dc_address = is_idle ? req_addr  : rmw_addr;
  assign dc_data_in = is_idle ? req_wdata : merged;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .ld_word   (dc_data_out),
    .ld_lane   (req_addr[1:0]),
    .ld_size   (req_size),
    .ld_signed (req_signed),
    .ld_data   (ld_data),
    .st_old    (rmw_word),
    .st_new    (rmw_wdata),
    .st_lane   (rmw_addr[1:0]),
    .st_half   (rmw_half),
    .st_merged (merged)
  );

  // FSM, RMW latches and writeback registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rmw_addr  <= '0;
      rmw_word  <= '0;
      rmw_wdata <= '0;
      rmw_half  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
    end else begin
      wb_valid <= do_load;
      if (do_load) wb_data <= ld_data;
      case (state)
        IDLE: if (do_rmw) begin
          state     <= RMW;
          rmw_addr  <= req_addr;
          rmw_word  <= dc_data_out;
          rmw_wdata <= req_wdata[HALF_W-1:0];
          rmw_half  <= (req_size == SZ_HALF);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;

  // One-cycle flag for a suppressed misaligned access
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) misalign_q <= 1'b0;
    else     misalign_q <= is_idle & mis;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with an 8-word cache model and a
// scoreboard queue of expected load results.
module tb_lsu_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, dc_read, dc_write, wb_valid, misalign;
  logic [31:0] dc_address, dc_data_in, dc_data_out, wb_data;

  logic [31:0] mem [8];
  logic        init_mem = 1'b1;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  lsu_mem_stage #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .dc_address(dc_address), .dc_data_in(dc_data_in),
    .dc_read(dc_read), .dc_write(dc_write), .dc_data_out(dc_data_out),
    .wb_valid(wb_valid), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  // Cache model: combinational read, write committed at the edge
  assign dc_data_out = mem[dc_address[4:2]];
  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 8; i++) mem[i] <= i;
    end else if (dc_write) begin
      mem[dc_address[4:2]] <= dc_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every writeback must match the oldest outstanding load
  always @(negedge CLK) begin
    if (!RST && wb_valid) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else chk("wb_data", wb_data, exp_q.pop_front());
    end
  end

  task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = d;
  endtask

  // One load cycle: check strobes, queue expectation, confirm wb_valid next
  task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic [31:0] expv);
    drive(1'b1, 1'b0, sz, sg, a, 32'h0);
    #1;
    chk("ld_dc_read", dc_read, 1'b1);
    chk("ld_dc_write", dc_write, 1'b0);
    chk("ld_stall", stall, 1'b0);
    exp_q.push_back(expv);
    @(posedge CLK); #1;
    chk("ld_wb_valid", wb_valid, 1'b1);
    @(negedge CLK);
  endtask

  // Sub-word store: stall cycle, then RMW write of the merged word
  task automatic sst(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] merged);
    drive(1'b1, 1'b1, sz, 1'b0, a, d);
    #1;
    chk("st_stall", stall, 1'b1);
    chk("st_dc_read", dc_read, 1'b1);
    chk("st_dc_write0", dc_write, 1'b0);
    @(posedge CLK); @(negedge CLK);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rmw_stall", stall, 1'b0);
    chk("rmw_dc_write", dc_write, 1'b1);
    chk("rmw_dc_read", dc_read, 1'b0);
    chk("rmw_addr", dc_address, a);
    chk("rmw_data", dc_data_in, merged);
    @(posedge CLK); #1;
    chk("rmw_wb_valid", wb_valid, 1'b0);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dc_read", dc_read, 1'b0);
    chk("rst_dc_write", dc_write, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h4, 32'h0);
    #1;
    chk("rst_stall", stall, 1'b0);
    @(negedge CLK);
    RST = 1'b0; init_mem = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("idle_dc_read", dc_read, 1'b0);
    chk("idle_dc_write", dc_write, 1'b0);
    @(negedge CLK);

    // Word load, then idle
    ld(2'd2, 1'b0, 32'h0C, 32'h00000003);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    chk("idle_wb_valid", wb_valid, 1'b0);
    @(negedge CLK);

    // Byte store then signed/unsigned byte loads
    sst(2'd0, 32'h09, 32'h000000AB, 32'h0000AB02);
    ld(2'd0, 1'b1, 32'h09, 32'hFFFFFFAB);
    ld(2'd0, 1'b0, 32'h09, 32'h000000AB);

    // Half store into upper lane of word 5
    sst(2'd1, 32'h16, 32'h00008001, 32'h80010005);
    ld(2'd1, 1'b1, 32'h16, 32'hFFFF8001);
    ld(2'd1, 1'b0, 32'h16, 32'h00008001);
    ld(2'd1, 1'b1, 32'h14, 32'h00000005);

    // Word store: single cycle, no stall
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h1C, 32'hDEADBEEF);
    #1;
    chk("sw_stall", stall, 1'b0);
    chk("sw_dc_write", dc_write, 1'b1);
    chk("sw_dc_read", dc_read, 1'b0);
    chk("sw_data", dc_data_in, 32'hDEADBEEF);
    @(posedge CLK); #1;
    chk("sw_wb_valid", wb_valid, 1'b0);
    @(negedge CLK);
    ld(2'd2, 1'b0, 32'h1C, 32'hDEADBEEF);
    ld(2'd3, 1'b0, 32'h00, 32'h00000000);

    // Reset during RMW aborts the write
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h04, 32'h00000055);
    #1;
    chk("abort_stall0", stall, 1'b1);
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("abort_dc_write", dc_write, 1'b0);
    chk("abort_stall", stall, 1'b0);
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_wb_valid", wb_valid, 1'b0);
    chk("abort_idle_write", dc_write, 1'b0);
    @(negedge CLK);
    ld(2'd2, 1'b0, 32'h04, 32'h00000001);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
    #1;
    chk("mis_dc_read", dc_read, 1'b0);
    chk("mis_dc_write", dc_write, 1'b0);
    @(posedge CLK); #1;
    chk("mis_flag", misalign, 1'b1);
    chk("mis_wb_valid", wb_valid, 1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    chk("mis_flag_clear", misalign, 1'b0);
    @(negedge CLK);
`else
    ld(2'd2, 1'b0, 32'h0E, 32'h00000003);
    chk("mis_flag_off", misalign, 1'b0);
`endif

    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
